decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction-decode pipeline stage between fetch and execute in the rv32 core.
- Registers one fetched instruction per handshake and decodes it into the shared control record (invalid/bubble/kill/jump, op1_sel, op2_sel) plus register addresses and immediate.
- Inserts a one-cycle bubble on load-use hazards.
- On a flush from execute, converts its held instruction into a killed (side-effect-free) slot.

Parameters:
- XLEN, 32, datapath/PC width (only 32 supported).
- RESET_PC, 32'h0000_0000, value of id_pc after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  stage accepts the instruction this cycle.
- if_pc  in  32  PC of fetched instruction.
- if_insn  in  32  fetched instruction word.
- ex_ready  in  1  execute accepts the current decode output.
- flush  in  1  taken branch/jump resolved in execute.
- ex_load_valid  in  1  execute holds a load.
- ex_load_rd  in  5  destination register of that load.
- id_valid  out  1  decode output valid.
- id_pc  out  32  PC of decoded instruction.
- id_rs1, id_rs2, id_rd  out  5 each  register addresses (forced 0 when unused).
- id_imm  out  32  sign-extended immediate selected by format.
- id_ctrl  out  ctrl_t  control record.

Behaviour:
- Reset (resetn=0 at edge):
  - id_valid=0, id_pc=RESET_PC, addresses=0, id_imm=0.
  - id_ctrl all flags 0, op1_sel=RS1, op2_sel=RS2.
  - FSM to RUN.
  - Reset mid-transfer discards everything.
- Handshake:
  - if_ready = resetn && (!id_valid || ex_ready) && state==RUN && !hazard.
  - Accept on if_valid && if_ready; outputs appear next cycle (latency 1).
  - While id_valid && !ex_ready, all outputs hold stable.
- Hazard:
  - hazard = ex_load_valid && ex_load_rd!=0 && ((uses_rs1 && rs1==ex_load_rd) || (uses_rs2 && rs2==ex_load_rd)), evaluated on if_insn.
- FSM states RUN, BUBBLE:
  - RUN→BUBBLE when if_valid && hazard && (!id_valid || ex_ready). The register loads a bubble slot: id_valid=1, bubble=1, rd=0, jump=0, invalid=0. The instruction is not accepted.
  - BUBBLE→RUN once the bubble transfers (ex_ready=1). if_ready=0 in BUBBLE.
- Decode (opcode insn[6:2], insn[1:0] must be 2'b11):
  - LUI: RS1 (rs1 forced 0) + U_IMM.
  - AUIPC: PC + U_IMM.
  - JAL: PC + FOUR, jump=1, imm=J.
  - JALR: PC + FOUR, jump=1, imm=I.
  - BRANCH: RS1 + RS2, jump=1, imm=B, rd=0.
  - LOAD: RS1 + I_IMM.
  - STORE: RS1 + S_IMM, rd=0.
  - OP-IMM: RS1 + I_IMM.
  - OP: RS1 + RS2; funct7 must be 0000000, or 0100000 for SUB/SRA.
  - MISC-MEM/SYSTEM: RS1 + I_IMM.
  - Anything else: invalid=1, jump=0, rd=0.
- Flush:
  - If the register holds a valid entry, it stays valid with kill=1, rd=0, jump=0.
  - The instruction presented this cycle is dropped (if_ready=0).
  - The FSM returns to RUN.
  - Flush has priority over hazard/bubble and accept.
  - kill clears when the slot transfers.

Optional Feature:
- Macro RV32M_EN.
  - Defined: OP with funct7=0000001 (MUL..REMU) decodes as valid RS1 + RS2.
  - Undefined: the same encodings set invalid=1 and rd=0.

Decomposition:
- Package ctrl gains:
  - opcode enum opcode_t (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM);
  - imm format enum;
  - funct7 constants;
  - decode-state enum {RUN, BUBBLE}.
- Pure combinational sub-module decoder (insn → ctrl_t, rs1/rs2/rd, imm, uses_rs1/uses_rs2).
- decode_stage wraps it with the register, FSM and hazard logic.

Test Plan:
- Reset with resetn=0 for 2 cycles → id_valid=0, id_pc=0, op1_sel=RS1, op2_sel=RS2, if_ready=1 after release.
- ADDI x1,x0,5 (0x00500093) at pc 0x10, ex_ready=1 → next cycle id_valid=1, rd=1, imm=5, op2_sel=I_IMM, invalid=0.
- Load-use hazard:
  - Stimulus: ex_load_valid=1, ex_load_rd=1, if_insn=ADD x2,x1,x1.
  - Response: if_ready=0, one bubble slot (bubble=1, rd=0), then the ADD is accepted the following cycle.
- Backpressure: JAL x1,+8 held with ex_ready=0 for 3 cycles → outputs stable (jump=1, op1_sel=PC, op2_sel=FOUR, imm=8), if_ready=0.
- Flush and hazard in the same cycle → held slot gets kill=1, incoming instruction dropped, no bubble, state RUN.
- MUL x3,x1,x2 (0x022081B3) → invalid=0 with RV32M_EN, invalid=1 and rd=0 without; opcode 7'b1111111 → invalid=1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the rv32 decode stage.
//   opcode_t   : major opcodes (insn[6:2]) understood by the decoder
//   imm_fmt_t  : immediate formats
//   op1_sel_t / op2_sel_t : execute operand selects
//   ctrl_t     : control record handed to execute
//   state_t    : decode-stage FSM states
//   gen_imm()  : sign-extended immediate extraction by format
package decode_stage_pkg;

    typedef enum logic [4:0] {
        OPC_LOAD     = 5'b00000,
        OPC_MISC_MEM = 5'b00011,
        OPC_OP_IMM   = 5'b00100,
        OPC_AUIPC    = 5'b00101,
        OPC_STORE    = 5'b01000,
        OPC_OP       = 5'b01100,
        OPC_LUI      = 5'b01101,
        OPC_BRANCH   = 5'b11000,
        OPC_JALR     = 5'b11001,
        OPC_JAL      = 5'b11011,
        OPC_SYSTEM   = 5'b11100
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;  // SUB / SRA
    localparam logic [6:0] F7_MULDIV = 7'b0000001;  // MUL..REMU

    typedef enum logic {
        OP1_RS1,
        OP1_PC
    } op1_sel_t;

    typedef enum logic [2:0] {
        OP2_RS2,
        OP2_I_IMM,
        OP2_S_IMM,
        OP2_U_IMM,
        OP2_FOUR
    } op2_sel_t;

    typedef struct packed {
        logic     invalid;
        logic     bubble;
        logic     kill;
        logic     jump;
        op1_sel_t op1_sel;
        op2_sel_t op2_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        invalid: 1'b0,
        bubble:  1'b0,
        kill:    1'b0,
        jump:    1'b0,
        op1_sel: OP1_RS1,
        op2_sel: OP2_RS2
    };

    typedef enum logic {
        ST_RUN,
        ST_BUBBLE
    } state_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] insn, input imm_fmt_t fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{insn[31]}}, insn[31:20]};
            IMM_S:   imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_B:   imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            IMM_U:   imm = {insn[31:12], 12'b0};
            IMM_J:   imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_decoder.sv
// Pure combinational rv32 instruction decoder.
//   insn     in  : 32-bit instruction word
//   ctrl     out : control record (invalid/jump/op1_sel/op2_sel; bubble/kill always 0)
//   rs1/rs2/rd out : register addresses, 0 when the format does not use them
//   imm      out : sign-extended immediate for the format (0 when none)
//   uses_rs1/uses_rs2 out : instruction reads that source register
// Build option: define RV32M_EN to accept the M-extension OP encodings.
module decode_stage_decoder
    import decode_stage_pkg::*;
(
    input  logic [31:0] insn,
    output ctrl_t       ctrl,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic [4:0] f_rs1;
    logic [4:0] f_rs2;
    logic [4:0] f_rd;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       op_ok;
    imm_fmt_t   fmt;

    assign f_rs1 = insn[19:15];
    assign f_rs2 = insn[24:20];
    assign f_rd  = insn[11:7];
    assign f3    = insn[14:12];
    assign f7    = insn[31:25];

    always_comb begin
        op_ok = (f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
`ifdef RV32M_EN
        op_ok = op_ok || (f7 == F7_MULDIV);
`else
        op_ok = op_ok && (f7 != F7_MULDIV);
`endif
    end

    always_comb begin
        ctrl     = CTRL_RESET;
        rs1      = 5'd0;
        rs2      = 5'd0;
        rd       = 5'd0;
        fmt      = IMM_NONE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;

        if (insn[1:0] != 2'b11) begin
            ctrl.invalid = 1'b1;
        end else begin
            case (insn[6:2])
                OPC_LUI: begin
                    // rs1 reads x0 so execute adds U_IMM to zero
                    rd           = f_rd;
                    ctrl.op2_sel = OP2_U_IMM;
                    fmt          = IMM_U;
                end
                OPC_AUIPC: begin
                    rd           = f_rd;
                    ctrl.op1_sel = OP1_PC;
                    ctrl.op2_sel = OP2_U_IMM;
                    fmt          = IMM_U;
                end
                OPC_JAL: begin
                    rd           = f_rd;
                    ctrl.jump    = 1'b1;
                    ctrl.op1_sel = OP1_PC;
                    ctrl.op2_sel = OP2_FOUR;
                    fmt          = IMM_J;
                end
                OPC_JALR: begin
                    rs1          = f_rs1;
                    uses_rs1     = 1'b1;
                    rd           = f_rd;
                    ctrl.jump    = 1'b1;
                    ctrl.op1_sel = OP1_PC;
                    ctrl.op2_sel = OP2_FOUR;
                    fmt          = IMM_I;
                end
                OPC_BRANCH: begin
                    rs1       = f_rs1;
                    rs2       = f_rs2;
                    uses_rs1  = 1'b1;
                    uses_rs2  = 1'b1;
                    ctrl.jump = 1'b1;
                    fmt       = IMM_B;
                end
                OPC_STORE: begin
                    rs1          = f_rs1;
                    rs2          = f_rs2;
                    uses_rs1     = 1'b1;
                    uses_rs2     = 1'b1;
                    ctrl.op2_sel = OP2_S_IMM;
                    fmt          = IMM_S;
                end
                OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: begin
                    rs1          = f_rs1;
                    uses_rs1     = 1'b1;
                    rd           = f_rd;
                    ctrl.op2_sel = OP2_I_IMM;
                    fmt          = IMM_I;
                end
                OPC_OP: begin
                    if (op_ok) begin
                        rs1      = f_rs1;
                        rs2      = f_rs2;
                        uses_rs1 = 1'b1;
                        uses_rs2 = 1'b1;
                        rd       = f_rd;
                    end else begin
                        ctrl.invalid = 1'b1;
                    end
                end
                default: ctrl.invalid = 1'b1;
            endcase
        end

        imm = gen_imm(insn, fmt);
    end

endmodule

// File: rtl/decode_stage.sv
// rv32 instruction-decode pipeline stage (fetch -> decode -> execute).
//   clk, resetn          : clock, synchronous active-low reset
//   if_valid/if_ready    : fetch handshake; if_pc/if_insn carry the instruction
//   ex_ready             : execute takes the current id_* output this cycle
//   flush                : taken branch/jump in execute; kill held slot, drop input
//   ex_load_valid/ex_load_rd : load in execute, for load-use detection
//   id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_ctrl : registered decode output
//   state                : FSM state (RUN / BUBBLE) for observation
// Handshake: a slot moves when valid && ready are both high at a rising edge;
// id_* holds stable while id_valid && !ex_ready.
// Build option: RV32M_EN (see decode_stage_decoder).
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_insn,
    input  logic            ex_ready,
    input  logic            flush,
    input  logic            ex_load_valid,
    input  logic [4:0]      ex_load_rd,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [31:0]     id_imm,
    output ctrl_t           id_ctrl,
    output state_t          state
);

    ctrl_t       dec_ctrl;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic        dec_uses_rs1;
    logic        dec_uses_rs2;
    logic        hazard;
    logic        can_load;

    decode_stage_decoder u_decoder (
        .insn     (if_insn),
        .ctrl     (dec_ctrl),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .imm      (dec_imm),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2)
    );

    // Load-use: the incoming instruction reads the register an in-flight load writes.
    assign hazard = ex_load_valid && (ex_load_rd != 5'd0) &&
                    ((dec_uses_rs1 && (dec_rs1 == ex_load_rd)) ||
                     (dec_uses_rs2 && (dec_rs2 == ex_load_rd)));

    // The output register is free when empty or being drained this cycle.
    assign can_load = !id_valid || ex_ready;

    assign if_ready = resetn && can_load && (state == ST_RUN) && !hazard && !flush;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_RUN;
            id_valid <= 1'b0;
            id_pc    <= RESET_PC;
            id_rs1   <= 5'd0;
            id_rs2   <= 5'd0;
            id_rd    <= 5'd0;
            id_imm   <= 32'd0;
            id_ctrl  <= CTRL_RESET;
        end else if (flush) begin
            // Held slot stays visible but can no longer write rd or redirect.
            if (id_valid) begin
                id_ctrl.kill <= 1'b1;
                id_ctrl.jump <= 1'b0;
                id_rd        <= 5'd0;
            end
            state <= ST_RUN;
        end else if (state == ST_BUBBLE) begin
            if (ex_ready) begin
                id_valid       <= 1'b0;
                id_ctrl.bubble <= 1'b0;
                id_ctrl.kill   <= 1'b0;
                state          <= ST_RUN;
            end
        end else if (can_load) begin
            if (if_valid && hazard) begin
                // Bubble slot: valid but inert; the instruction waits at fetch.
                id_valid <= 1'b1;
                id_rs1   <= 5'd0;
                id_rs2   <= 5'd0;
                id_rd    <= 5'd0;
                id_imm   <= 32'd0;
                id_ctrl  <= '{invalid: 1'b0, bubble: 1'b1, kill: 1'b0, jump: 1'b0,
                              op1_sel: OP1_RS1, op2_sel: OP2_RS2};
                state    <= ST_BUBBLE;
            end else if (if_valid) begin
                id_valid <= 1'b1;
                id_pc    <= if_pc;
                id_rs1   <= dec_rs1;
                id_rs2   <= dec_rs2;
                id_rd    <= dec_rd;
                id_imm   <= dec_imm;
                id_ctrl  <= dec_ctrl;
            end else begin
                id_valid       <= 1'b0;
                id_ctrl.bubble <= 1'b0;
                id_ctrl.kill   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam logic [31:0] INSN_ADDI = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] INSN_ADD  = 32'h0010_8133;  // add  x2,x1,x1
    localparam logic [31:0] INSN_JAL  = 32'h0080_00EF;  // jal  x1,+8
    localparam logic [31:0] INSN_BEQ  = 32'h0020_8863;  // beq  x1,x2,+16
    localparam logic [31:0] INSN_SW   = 32'h0020_A623;  // sw   x2,12(x1)
    localparam logic [31:0] INSN_MUL  = 32'h0220_81B3;  // mul  x3,x1,x2
    localparam logic [31:0] INSN_BAD  = 32'h0000_01FF;  // opcode 7'b1111111, rd field 3

    logic        clk;
    logic        resetn;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_insn;
    logic        ex_ready;
    logic        flush;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rd;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    ctrl_t       id_ctrl;
    state_t      state;

    int n_tests;
    int n_fail;

    decode_stage dut (
        .clk           (clk),
        .resetn        (resetn),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_pc         (if_pc),
        .if_insn       (if_insn),
        .ex_ready      (ex_ready),
        .flush         (flush),
        .ex_load_valid (ex_load_valid),
        .ex_load_rd    (ex_load_rd),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_imm        (id_imm),
        .id_ctrl       (id_ctrl),
        .state         (state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present one instruction at a negedge, expect it accepted at the next
    // posedge, and return at the following negedge with fetch idle.
    task automatic send(input string tag, input logic [31:0] pc, input logic [31:0] insn);
        if_valid = 1'b1;
        if_pc    = pc;
        if_insn  = insn;
        #1;
        check({tag, "_rdy"}, if_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if_valid = 1'b0;
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        resetn        = 1'b0;
        if_valid      = 1'b0;
        if_pc         = 32'd0;
        if_insn       = 32'd0;
        ex_ready      = 1'b1;
        flush         = 1'b0;
        ex_load_valid = 1'b0;
        ex_load_rd    = 5'd0;

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", id_valid, 0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_rd", id_rd, 0);
        check("rst_imm", id_imm, 0);
        check("rst_op1", id_ctrl.op1_sel, OP1_RS1);
        check("rst_op2", id_ctrl.op2_sel, OP2_RS2);
        check("rst_flags", {id_ctrl.invalid, id_ctrl.bubble, id_ctrl.kill, id_ctrl.jump}, 0);
        check("rst_ready", if_ready, 0);
        check("rst_state", state, ST_RUN);
        resetn = 1'b1;
        #1;
        check("rel_ready", if_ready, 1);

        // ADDI x1,x0,5
        send("addi", 32'h10, INSN_ADDI);
        check("addi_valid", id_valid, 1);
        check("addi_pc", id_pc, 32'h10);
        check("addi_rd", id_rd, 1);
        check("addi_rs1", id_rs1, 0);
        check("addi_imm", id_imm, 5);
        check("addi_op2", id_ctrl.op2_sel, OP2_I_IMM);
        check("addi_op1", id_ctrl.op1_sel, OP1_RS1);
        check("addi_invalid", id_ctrl.invalid, 0);

        // load-use hazard: ADD x2,x1,x1 behind a load of x1
        if_valid      = 1'b1;
        if_pc         = 32'h14;
        if_insn       = INSN_ADD;
        ex_load_valid = 1'b1;
        ex_load_rd    = 5'd1;
        #1;
        check("hz_ready", if_ready, 0);
        @(posedge clk);
        @(negedge clk);
        ex_load_valid = 1'b0;
        #1;
        check("hz_state", state, ST_BUBBLE);
        check("hz_valid", id_valid, 1);
        check("hz_bubble", id_ctrl.bubble, 1);
        check("hz_rd", id_rd, 0);
        check("hz_jump", id_ctrl.jump, 0);
        check("hz_bub_ready", if_ready, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("hz_post_state", state, ST_RUN);
        check("hz_post_valid", id_valid, 0);
        check("hz_post_ready", if_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if_valid = 1'b0;
        #1;
        check("add_valid", id_valid, 1);
        check("add_pc", id_pc, 32'h14);
        check("add_rd", id_rd, 2);
        check("add_rs1", id_rs1, 1);
        check("add_rs2", id_rs2, 1);
        check("add_bubble", id_ctrl.bubble, 0);
        check("add_op2", id_ctrl.op2_sel, OP2_RS2);

        // backpressure: JAL x1,+8 held for 3 cycles
        send("jal", 32'h20, INSN_JAL);
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_pc    = 32'h24;
        if_insn  = INSN_ADDI;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("bp_valid", id_valid, 1);
            check("bp_pc", id_pc, 32'h20);
            check("bp_jump", id_ctrl.jump, 1);
            check("bp_op1", id_ctrl.op1_sel, OP1_PC);
            check("bp_op2", id_ctrl.op2_sel, OP2_FOUR);
            check("bp_imm", id_imm, 8);
            check("bp_rd", id_rd, 1);
            check("bp_ready", if_ready, 0);
        end

        // flush together with a hazard-causing instruction
        ex_ready      = 1'b1;
        flush         = 1'b1;
        ex_load_valid = 1'b1;
        ex_load_rd    = 5'd1;
        if_insn       = INSN_ADD;
        #1;
        check("fl_ready", if_ready, 0);
        @(posedge clk);
        @(negedge clk);
        flush         = 1'b0;
        ex_load_valid = 1'b0;
        if_valid      = 1'b0;
        ex_ready      = 1'b0;
        #1;
        check("fl_valid", id_valid, 1);
        check("fl_kill", id_ctrl.kill, 1);
        check("fl_rd", id_rd, 0);
        check("fl_jump", id_ctrl.jump, 0);
        check("fl_bubble", id_ctrl.bubble, 0);
        check("fl_state", state, ST_RUN);
        check("fl_pc", id_pc, 32'h20);
        ex_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("fl_drain_valid", id_valid, 0);
        check("fl_drain_kill", id_ctrl.kill, 0);

        // branch and store formats
        send("beq", 32'h30, INSN_BEQ);
        check("beq_jump", id_ctrl.jump, 1);
        check("beq_imm", id_imm, 16);
        check("beq_rd", id_rd, 0);
        check("beq_rs2", id_rs2, 2);
        check("beq_op2", id_ctrl.op2_sel, OP2_RS2);
        send("sw", 32'h34, INSN_SW);
        check("sw_imm", id_imm, 12);
        check("sw_op2", id_ctrl.op2_sel, OP2_S_IMM);
        check("sw_rd", id_rd, 0);
        check("sw_rs2", id_rs2, 2);

        // M-extension encoding
        send("mul", 32'h38, INSN_MUL);
`ifdef RV32M_EN
        check("mul_invalid", id_ctrl.invalid, 0);
        check("mul_rd", id_rd, 3);
`else
        check("mul_invalid", id_ctrl.invalid, 1);
        check("mul_rd", id_rd, 0);
`endif

        // unknown opcode
        send("bad", 32'h3C, INSN_BAD);
        check("bad_invalid", id_ctrl.invalid, 1);
        check("bad_rd", id_rd, 0);
        check("bad_jump", id_ctrl.jump, 0);

        // reset while a slot is held
        send("mid", 32'h40, INSN_ADDI);
        ex_ready = 1'b0;
        check("mid_valid", id_valid, 1);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("mid_rst_valid", id_valid, 0);
        check("mid_rst_pc", id_pc, 32'h0);
        check("mid_rst_rd", id_rd, 0);
        resetn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
